// File: rtl/ir_fetch_loader_if.sv
// Bus bundle between ir_fetch_loader and its cache / IR register file.
//   init, en      : sequence start requests (sampled only in IDLE)
//   data_in       : cache read data, valid the cycle after cache_ren
//   cache_ren     : cache read strobe, addr_bus its address
//   ir_wen        : IR register file write strobe, ir_waddr / ir_wdata
//   ir, operands  : last fetched opcode and operand words
//   ir_valid      : pulse when ir/operands update
//   busy, done    : activity level and completion pulse
interface ir_fetch_loader_if #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned NUM_OPERANDS = 3
);
    logic                               init;
    logic                               en;
    logic [DATA_WIDTH-1:0]              data_in;
    logic                               cache_ren;
    logic [ADDR_WIDTH-1:0]              addr_bus;
    logic                               ir_wen;
    logic [ADDR_WIDTH-1:0]              ir_waddr;
    logic [DATA_WIDTH-1:0]              ir_wdata;
    logic [DATA_WIDTH-1:0]              ir;
    logic [NUM_OPERANDS*DATA_WIDTH-1:0] operands;
    logic                               ir_valid;
    logic                               busy;
    logic                               done;

    // Environment side: drives requests and cache data.
    modport master (
        output init, en, data_in,
        input  cache_ren, addr_bus, ir_wen, ir_waddr, ir_wdata,
        input  ir, operands, ir_valid, busy, done
    );

    // Loader side.
    modport slave (
        input  init, en, data_in,
        output cache_ren, addr_bus, ir_wen, ir_waddr, ir_wdata,
        output ir, operands, ir_valid, busy, done
    );
endinterface

// File: rtl/ir_fetch_loader.sv
// Instruction fetch / IR register file loader.
// Copies INIT_LINES cache words into the IR register file on init, fetches
// one opcode plus NUM_OPERANDS operands at pc on en, and for LOAD_OPCODE
// copies operand2 words from cache[operand0] to IR file[operand1].
// Ports: clk, rst_n (async active-low), bus (ir_fetch_loader_if.slave).
// Strobes and addresses are decoded from the current state so a read or
// write is visible in the same cycle as its state; ir/operands, ir_valid and
// done are registered.
module ir_fetch_loader #(
    parameter int unsigned           DATA_WIDTH   = 8,
    parameter int unsigned           ADDR_WIDTH   = 8,
    parameter int unsigned           INIT_LINES   = 256,
    parameter int unsigned           NUM_OPERANDS = 3,
    parameter logic [DATA_WIDTH-1:0] LOAD_OPCODE  = DATA_WIDTH'(1)
) (
    input  logic              clk,
    input  logic              rst_n,
    ir_fetch_loader_if.slave  bus
);

    localparam int unsigned KW  = $clog2(NUM_OPERANDS + 1);
    localparam int unsigned OPW = NUM_OPERANDS * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_LINE = ADDR_WIDTH'(INIT_LINES - 1);
    localparam logic [KW-1:0]         LAST_K    = KW'(NUM_OPERANDS);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(NUM_OPERANDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_RD,
        S_INIT_WR,
        S_FETCH_RD,
        S_FETCH_CAP,
        S_LOAD_RD,
        S_LOAD_WR
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [KW-1:0]         k_q, k_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [OPW-1:0]        operands_q, operands_d;
    logic                  ir_valid_q, ir_valid_d;
    logic                  done_q, done_d;

    logic                  cache_ren_c;
    logic                  ir_wen_c;
    logic [ADDR_WIDTH-1:0] addr_c;
    logic [ADDR_WIDTH-1:0] waddr_c;
    logic [DATA_WIDTH-1:0] wdata_c;
    logic [DATA_WIDTH-1:0] op0_c, op1_c, op2_c;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            k_q        <= '0;
            pc_q       <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            rem_q      <= '0;
            ir_q       <= '0;
            operands_q <= '0;
            ir_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            pc_q       <= pc_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            rem_q      <= rem_d;
            ir_q       <= ir_d;
            operands_q <= operands_d;
            ir_valid_q <= ir_valid_d;
            done_q     <= done_d;
        end
    end

    // Next-state, datapath updates and state-decoded strobes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        pc_d        = pc_q;
        src_d       = src_q;
        dst_d       = dst_q;
        rem_d       = rem_q;
        ir_d        = ir_q;
        operands_d  = operands_q;
        ir_valid_d  = 1'b0;
        done_d      = 1'b0;
        cache_ren_c = 1'b0;
        ir_wen_c    = 1'b0;
        addr_c      = '0;
        waddr_c     = '0;
        wdata_c     = '0;
        op0_c       = '0;
        op1_c       = '0;
        op2_c       = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.init) begin
                    state_d = S_INIT_RD;
                    cnt_d   = '0;
                end else if (bus.en) begin
                    state_d = S_FETCH_RD;
                    k_d     = '0;
                end
            end

            S_INIT_RD: begin
                cache_ren_c = 1'b1;
                addr_c      = cnt_q;
                state_d     = S_INIT_WR;
            end

            S_INIT_WR: begin
                ir_wen_c = 1'b1;
                waddr_c  = cnt_q;
                wdata_c  = bus.data_in;
                if (cnt_q == LAST_LINE) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + ADDR_WIDTH'(1);
                    state_d = S_INIT_RD;
                end
            end

            S_FETCH_RD: begin
                cache_ren_c = 1'b1;
                addr_c      = pc_q + ADDR_WIDTH'(k_q);
                state_d     = S_FETCH_CAP;
            end

            S_FETCH_CAP: begin
                // k=0 is the opcode, k>=1 lands in operand k-1.
                if (k_q == '0) begin
                    ir_d = bus.data_in;
                end
                for (int unsigned i = 0; i < NUM_OPERANDS; i++) begin
                    if (k_q == KW'(i + 1)) begin
                        operands_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.data_in;
                    end
                end
                if (k_q != LAST_K) begin
                    k_d     = k_q + KW'(1);
                    state_d = S_FETCH_RD;
                end else begin
                    // Decide on the freshly captured operands, not the stale ones.
                    op0_c      = operands_d[0 +: DATA_WIDTH];
                    op1_c      = operands_d[DATA_WIDTH +: DATA_WIDTH];
                    op2_c      = operands_d[2*DATA_WIDTH +: DATA_WIDTH];
                    pc_d       = pc_q + PC_STEP;
                    ir_valid_d = 1'b1;
                    if ((ir_q == LOAD_OPCODE) && (op2_c != '0)) begin
                        src_d   = ADDR_WIDTH'(op0_c);
                        dst_d   = ADDR_WIDTH'(op1_c);
                        rem_d   = op2_c;
                        state_d = S_LOAD_RD;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            S_LOAD_RD: begin
                cache_ren_c = 1'b1;
                addr_c      = src_q;
                state_d     = S_LOAD_WR;
            end

            S_LOAD_WR: begin
                ir_wen_c = 1'b1;
                waddr_c  = dst_q;
                wdata_c  = bus.data_in;
                src_d    = src_q + ADDR_WIDTH'(1);
                dst_d    = dst_q + ADDR_WIDTH'(1);
                rem_d    = rem_q - DATA_WIDTH'(1);
                if (rem_q == DATA_WIDTH'(1)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LOAD_RD;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.cache_ren = cache_ren_c;
    assign bus.addr_bus  = addr_c;
    assign bus.ir_wen    = ir_wen_c;
    assign bus.ir_waddr  = waddr_c;
    assign bus.ir_wdata  = wdata_c;
    assign bus.ir        = ir_q;
    assign bus.operands  = operands_q;
    assign bus.ir_valid  = ir_valid_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ir_fetch_loader.sv
// Directed self-checking bench for ir_fetch_loader (INIT_LINES=4).
module tb_ir_fetch_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ir_fetch_loader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_OPERANDS(3)) bus_if ();

    ir_fetch_loader #(
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (8),
        .INIT_LINES  (4),
        .NUM_OPERANDS(3),
        .LOAD_OPCODE (8'h01)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    logic [7:0] cache [256];

    // Synchronous cache model: data appears the cycle after the read strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus_if.data_in <= 8'h00;
        else if (bus_if.cache_ren) bus_if.data_in <= cache[bus_if.addr_bus];
    end

    // Monitor: sampled mid-cycle, owns all recorded activity.
    logic [15:0] wr_q [$];
    logic [7:0]  rd_q [$];
    int busy_cnt = 0, done_cnt = 0, iv_cnt = 0, overlap = 0, cyc = 0;
    int done_cyc = 0, iv_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (bus_if.ir_wen) wr_q.push_back({bus_if.ir_waddr, bus_if.ir_wdata});
        if (bus_if.cache_ren) rd_q.push_back(bus_if.addr_bus);
        if (bus_if.busy) busy_cnt++;
        if (bus_if.done) begin done_cnt++; done_cyc = cyc; end
        if (bus_if.ir_valid) begin iv_cnt++; iv_cyc = cyc; end
        if (bus_if.cache_ren && bus_if.ir_wen) overlap++;
    end

    int n_err = 0, n_checks = 0;
    int wr0, rd0, busy0, done0, iv0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mark();
        wr0 = wr_q.size(); rd0 = rd_q.size();
        busy0 = busy_cnt; done0 = done_cnt; iv0 = iv_cnt;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == done0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("done_timeout", 64'(done_cnt == done0), 64'd0);
    endtask

    task automatic do_fetch();
        mark();
        @(negedge clk); bus_if.en = 1'b1;
        @(negedge clk); bus_if.en = 1'b0;
        wait_done(60);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reads(input string tag, input int base, input logic [7:0] a0);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] exp_a;
            exp_a = a0 + 8'(i);
            check(tag, 64'(rd_q[base+i]), 64'(exp_a));
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        check({tag, "_ren"},   64'(bus_if.cache_ren), 64'd0);
        check({tag, "_wen"},   64'(bus_if.ir_wen),    64'd0);
        check({tag, "_busy"},  64'(bus_if.busy),      64'd0);
        check({tag, "_addr"},  64'(bus_if.addr_bus),  64'd0);
        check({tag, "_waddr"}, 64'(bus_if.ir_waddr),  64'd0);
        check({tag, "_wdata"}, 64'(bus_if.ir_wdata),  64'd0);
        check({tag, "_ir"},    64'(bus_if.ir),        64'd0);
        check({tag, "_ops"},   64'(bus_if.operands),  64'd0);
        check({tag, "_done"},  64'(bus_if.done),      64'd0);
        check({tag, "_iv"},    64'(bus_if.ir_valid),  64'd0);
    endtask

    initial begin
        bus_if.init = 1'b0;
        bus_if.en   = 1'b0;
        for (int i = 0; i < 256; i++) cache[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        #1 chk_outputs_zero("reset");
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Init copy of four lines
        for (int i = 0; i < 4; i++) cache[i] = 8'hA0 + 8'(i);
        mark();
        bus_if.init = 1'b1;
        @(negedge clk); bus_if.init = 1'b0;
        wait_done(40);
        repeat (3) @(negedge clk);
        check("init_nwr", 64'(wr_q.size() - wr0), 64'd4);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] exp_w;
            exp_w = {8'(i), 8'hA0 + 8'(i)};
            check("init_wr", 64'(wr_q[wr0+i]), 64'(exp_w));
        end
        check("init_busy", 64'(busy_cnt - busy0), 64'd8);
        check("init_done", 64'(done_cnt - done0), 64'd1);
        check("init_iv",   64'(iv_cnt - iv0),     64'd0);

        // init and en together, en held through the init
        mark();
        bus_if.init = 1'b1; bus_if.en = 1'b1;
        @(negedge clk); bus_if.init = 1'b0;
        wait_done(40);
        bus_if.en = 1'b0;
        repeat (3) @(negedge clk);
        check("both_nwr",  64'(wr_q.size() - wr0), 64'd4);
        check("both_busy", 64'(busy_cnt - busy0),  64'd8);
        check("both_iv",   64'(iv_cnt - iv0),      64'd0);
        check("both_done", 64'(done_cnt - done0),  64'd1);

        // Plain fetch at pc=0
        cache[0] = 8'h05; cache[1] = 8'h11; cache[2] = 8'h22; cache[3] = 8'h33;
        do_fetch();
        chk_reads("f0_rd", rd0, 8'h00);
        check("f0_ir",   64'(bus_if.ir),       64'h05);
        check("f0_ops",  64'(bus_if.operands), 64'h332211);
        check("f0_iv",   64'(iv_cnt - iv0),    64'd1);
        check("f0_done", 64'(done_cnt - done0), 64'd1);
        check("f0_sync", 64'(done_cyc - iv_cyc), 64'd0);
        check("f0_nwr",  64'(wr_q.size() - wr0), 64'd0);
        check("f0_busy", 64'(busy_cnt - busy0), 64'd8);

        // Next fetch starts at pc=4
        cache[4] = 8'h09; cache[5] = 8'hAA; cache[6] = 8'hBB; cache[7] = 8'hCC;
        do_fetch();
        chk_reads("f1_rd", rd0, 8'h04);
        check("f1_ir",  64'(bus_if.ir),       64'h09);
        check("f1_ops", 64'(bus_if.operands), 64'hCCBBAA);

        // Reset during the third init write
        mark();
        @(negedge clk); bus_if.init = 1'b1;
        @(negedge clk); bus_if.init = 1'b0;
        for (int n = 0; n < 20 && (wr_q.size() - wr0) < 3; n++) begin
            @(negedge clk); #1;
        end
        check("rst_at_wr3", 64'(wr_q.size() - wr0), 64'd3);
        rst_n = 1'b0;
        #1 chk_outputs_zero("async_rst");
        @(negedge clk); rst_n = 1'b1;
        mark();
        repeat (10) @(negedge clk);
        check("rst_nwr",  64'(wr_q.size() - wr0), 64'd0);
        check("rst_busy", 64'(busy_cnt - busy0),  64'd0);
        check("rst_done", 64'(done_cnt - done0),  64'd0);

        // LOAD opcode with two-word block copy, pc restarts at 0
        cache[0] = 8'h01; cache[1] = 8'h10; cache[2] = 8'h40; cache[3] = 8'h02;
        cache[8'h10] = 8'h5A; cache[8'h11] = 8'h5B;
        do_fetch();
        check("ld_nrd", 64'(rd_q.size() - rd0), 64'd6);
        chk_reads("ld_frd", rd0, 8'h00);
        check("ld_src0", 64'(rd_q[rd0+4]), 64'h10);
        check("ld_src1", 64'(rd_q[rd0+5]), 64'h11);
        check("ld_nwr", 64'(wr_q.size() - wr0), 64'd2);
        check("ld_wr0", 64'(wr_q[wr0]),   64'h405A);
        check("ld_wr1", 64'(wr_q[wr0+1]), 64'h415B);
        check("ld_ir",  64'(bus_if.ir),       64'h01);
        check("ld_ops", 64'(bus_if.operands), 64'h024010);
        check("ld_iv",  64'(iv_cnt - iv0),    64'd1);
        check("ld_done", 64'(done_cnt - done0), 64'd1);
        check("ld_gap", 64'(done_cyc - iv_cyc), 64'd4);
        check("ld_busy", 64'(busy_cnt - busy0), 64'd12);

        // LOAD opcode with zero length: no writes, done with ir_valid
        cache[4] = 8'h01; cache[5] = 8'h10; cache[6] = 8'h40; cache[7] = 8'h00;
        do_fetch();
        chk_reads("lz_rd", rd0, 8'h04);
        check("lz_nwr", 64'(wr_q.size() - wr0), 64'd0);
        check("lz_sync", 64'(done_cyc - iv_cyc), 64'd0);
        check("lz_ops", 64'(bus_if.operands), 64'h004010);

        // Walk pc to FC, then fetch across the top of the address space
        for (int i = 0; i < 256; i++) cache[i] = 8'h00;
        for (int i = 0; i < 61; i++) do_fetch();
        cache[8'hFC] = 8'h05; cache[8'hFD] = 8'hA1; cache[8'hFE] = 8'hB2; cache[8'hFF] = 8'hC3;
        do_fetch();
        chk_reads("wrap_rd", rd0, 8'hFC);
        check("wrap_ir",  64'(bus_if.ir),       64'h05);
        check("wrap_ops", 64'(bus_if.operands), 64'hC3B2A1);
        do_fetch();
        chk_reads("wrap_pc", rd0, 8'h00);

        check("no_overlap", 64'(overlap), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ir_fetch_loader.md
IR_FETCH_LOADER -- requirements
Module: ir_fetch_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of cache words, instruction opcodes and operands.
REQ-002 Parameter ADDR_WIDTH, default 8, width of the cache and IR register file addresses.
REQ-003 Parameter INIT_LINES, default 256, number of words copied by an init sequence; range 1..2^ADDR_WIDTH.
REQ-004 Parameter NUM_OPERANDS, default 3, operand words following each opcode; minimum 3.
REQ-005 Parameter LOAD_OPCODE, default 8'h01, opcode value that triggers a block load.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-008 init  input  1  start the bulk copy from cache to the IR register file.
REQ-009 en  input  1  start one instruction fetch at pc.
REQ-010 data_in  input  DATA_WIDTH  cache read data; valid one cycle after cache_ren.
REQ-011 cache_ren  output  1  cache read strobe.
REQ-012 addr_bus  output  ADDR_WIDTH  cache read address.
REQ-013 ir_wen  output  1  IR register file write strobe.
REQ-014 ir_waddr  output  ADDR_WIDTH  IR register file write address.
REQ-015 ir_wdata  output  DATA_WIDTH  IR register file write data.
REQ-016 ir  output  DATA_WIDTH  last fetched opcode.
REQ-017 operands  output  NUM_OPERANDS*DATA_WIDTH  last fetched operands; operand k in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-018 ir_valid  output  1  one-cycle pulse when ir/operands are updated.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 done  output  1  one-cycle pulse when an init, fetch or load sequence completes.

Function
REQ-021 States: IDLE, INIT_RD, INIT_WR, FETCH_RD, FETCH_CAP, LOAD_RD, LOAD_WR.
REQ-022 In IDLE: init=1 -> INIT_RD with cnt=0; otherwise en=1 -> FETCH_RD with k=0; init takes priority when both are high.
REQ-023 init and en are ignored in every state other than IDLE.
REQ-024 INIT_RD: cache_ren=1, addr_bus=cnt; next state INIT_WR.
REQ-025 INIT_WR: ir_wen=1, ir_waddr=cnt, ir_wdata=data_in; if cnt==INIT_LINES-1 -> IDLE and done pulses the following cycle; otherwise cnt+1 and go to INIT_RD.
REQ-026 An init sequence occupies exactly 2*INIT_LINES busy cycles.
REQ-027 FETCH_RD: cache_ren=1, addr_bus=pc+k modulo 2^ADDR_WIDTH; next state FETCH_CAP.
REQ-028 FETCH_CAP: k=0 registers data_in into ir; k>=1 registers data_in into operand k-1; if k<NUM_OPERANDS, k+1 and go to FETCH_RD.
REQ-029 After the final operand capture, pc advances by 1+NUM_OPERANDS modulo 2^ADDR_WIDTH and ir_valid pulses the following cycle.
REQ-030 After the final capture, if ir==LOAD_OPCODE and operand2!=0, go to LOAD_RD with src=operand0, dst=operand1, rem=operand2; otherwise go to IDLE and pulse done with ir_valid.
REQ-031 LOAD_RD: cache_ren=1, addr_bus=src; next state LOAD_WR.
REQ-032 LOAD_WR: ir_wen=1, ir_waddr=dst, ir_wdata=data_in; src+1, dst+1, rem-1, all wrapping; if rem==1 -> IDLE and done pulses the following cycle, otherwise go to LOAD_RD.
REQ-033 A LOAD opcode with operand2==0 performs no writes; done pulses together with ir_valid.
REQ-034 cache_ren and ir_wen are never high in the same cycle; both are 0 in IDLE.
REQ-035 ir and operands hold their values until the next fetch capture; init does not alter them.

Reset
REQ-036 rst_n low forces the following immediately, including mid-sequence: state=IDLE, pc=0, cnt=0, ir=0, operands=0, all strobes/pulses=0, addr_bus=0, ir_waddr=0, ir_wdata=0.
REQ-037 After rst_n deasserts, the first sequence starts only from a new init or en sampled in IDLE; an interrupted sequence is never resumed.

Verification
REQ-038 INIT_LINES=4, cache[i]=8'hA0+i, pulse init -> writes (0,A0),(1,A1),(2,A2),(3,A3) on alternate cycles; busy for 8 cycles; single done pulse.
REQ-039 pc=0, cache = 05,11,22,33, pulse en -> ir=05, operands={33,22,11}, one ir_valid and one done pulse, pc=4, no ir_wen.
REQ-040 cache[0..3] = 01,10,40,02 with cache[10]=5A, cache[11]=5B, pulse en -> ir_valid, then writes (40,5A),(41,5B), then done; pc=4.
REQ-041 init and en high together in IDLE -> init sequence runs; en held high during init is ignored; pc remains 0.
REQ-042 pc=8'hFE, pulse en -> reads from FE, FF, 00, 01; pc becomes 02.
REQ-043 rst_n pulled low during the third INIT_WR -> all outputs 0 asynchronously; after release, no writes occur until init is pulsed again.
